// File: rtl/connectnet_pipe.sv
// connectnet_pipe: NCHAN independent FIFO channels sharing only clock and reset.
// Each channel stores up to DEPTH words of WIDTH bits and presents its oldest
// entry on OUT_DATA. IN_READY, OUT_VALID and OCCUPANCY come from the registered
// count, so nothing falls through from IN to OUT combinationally.
module connectnet_pipe #(
   parameter int NCHAN = 2,
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic [NCHAN*WIDTH-1:0]            IN_DATA,
   input  logic [NCHAN-1:0]                  IN_VALID,
   output logic [NCHAN-1:0]                  IN_READY,
   output logic [NCHAN*WIDTH-1:0]            OUT_DATA,
   output logic [NCHAN-1:0]                  OUT_VALID,
   input  logic [NCHAN-1:0]                  OUT_READY,
   output logic [NCHAN*($clog2(DEPTH)+1)-1:0] OCCUPANCY
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   for (genvar k = 0; k < NCHAN; k++) begin : g_chan
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wr_ptr;
      logic [AW-1:0]    rd_ptr;
      logic [CW-1:0]    count;
      logic             armed;
      logic             ready;
      logic             valid;
      logic             push;
      logic             pop;

      // Ready goes high as soon as reset drops, but "armed" stays low until the
      // first edge after release so that edge never takes a push.
      assign ready = !RST && (count < CW'(DEPTH));
      assign valid = (count != '0);
      assign push  = IN_VALID[k] && ready && armed;
      assign pop   = valid && OUT_READY[k];

      // Pointers wrap naturally because DEPTH is a power of two; count tracks
      // push/pop pairs, and a full channel cannot push in the cycle it pops.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            armed  <= 1'b0;
         end else begin
            armed <= 1'b1;
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end

      // Data storage carries no reset; stale words are hidden by the count.
      always_ff @(posedge CLK) begin
         if (push) begin
            mem[wr_ptr] <= IN_DATA[k*WIDTH +: WIDTH];
         end
      end

      assign IN_READY[k]                = ready;
      assign OUT_VALID[k]               = valid;
      assign OUT_DATA[k*WIDTH +: WIDTH] = mem[rd_ptr];
      assign OCCUPANCY[k*CW +: CW]      = count;
   end

endmodule

// File: tb/tb_connectnet_pipe.sv
// tb_connectnet_pipe: scoreboard bench for connectnet_pipe (NCHAN=2, WIDTH=8,
// DEPTH=4). The driver predicts acceptance from a queue-level model and pushes
// expected words; a negedge monitor pops them whenever the DUT hands one out.
module tb_connectnet_pipe;

   localparam int NCHAN = 2;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic                   CLK = 1'b0;
   logic                   RST;
   logic [NCHAN*WIDTH-1:0] IN_DATA;
   logic [NCHAN-1:0]       IN_VALID;
   logic [NCHAN-1:0]       IN_READY;
   logic [NCHAN*WIDTH-1:0] OUT_DATA;
   logic [NCHAN-1:0]       OUT_VALID;
   logic [NCHAN-1:0]       OUT_READY;
   logic [NCHAN*CW-1:0]    OCCUPANCY;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] expQ [NCHAN][$];
   int modelCnt [NCHAN];
   int cycCnt [NCHAN];
   bit monitorOn = 1'b0;

   connectnet_pipe #(.NCHAN(NCHAN), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_DATA   (IN_DATA),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OCCUPANCY (OCCUPANCY)
   );

   // Free-running 10-unit clock.
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock of stimulus: wait for an edge, drive inputs, and record what the
   // queue model says the coming edge will accept.
   task automatic applyStimulus(input logic [NCHAN-1:0] iv, input logic [NCHAN-1:0] ordy,
                                input logic [NCHAN*WIDTH-1:0] data);
      @(posedge CLK);
      #1;
      IN_VALID  = iv;
      OUT_READY = ordy;
      IN_DATA   = data;
      for (int k = 0; k < NCHAN; k++) begin
         bit pushOk;
         bit popOk;
         cycCnt[k] = modelCnt[k];
         pushOk = iv[k] && (modelCnt[k] < DEPTH);
         popOk  = ordy[k] && (modelCnt[k] > 0);
         if (pushOk) expQ[k].push_back(data[k*WIDTH +: WIDTH]);
         modelCnt[k] = modelCnt[k] + int'(pushOk) - int'(popOk);
      end
   endtask

   // Asynchronous reset pulse landing between edges, with immediate checks and
   // a push offered right after release that the first edge must ignore.
   task automatic doReset();
      @(posedge CLK);
      #2;
      RST       = 1'b1;
      IN_VALID  = '0;
      OUT_READY = '0;
      for (int k = 0; k < NCHAN; k++) begin
         expQ[k].delete();
         modelCnt[k] = 0;
         cycCnt[k]   = 0;
      end
      #1;
      checkOutput("rst_out_valid", 32'(OUT_VALID), 32'h0);
      checkOutput("rst_occupancy", 32'(OCCUPANCY), 32'h0);
      checkOutput("rst_in_ready", 32'(IN_READY), 32'h0);
      @(posedge CLK);
      #2;
      RST      = 1'b0;
      IN_VALID = '1;
      IN_DATA  = {NCHAN{8'hEE}};
      #1;
      checkOutput("release_in_ready", 32'(IN_READY), 32'(2'b11));
   endtask

   // Monitor: compare handshake flags and occupancy to the model and pop the
   // scoreboard whenever the DUT completes an output transfer.
   always @(negedge CLK) begin
      if (monitorOn) begin
         for (int k = 0; k < NCHAN; k++) begin
            checkOutput($sformatf("in_ready[%0d]", k), 32'(IN_READY[k]),
                        32'(!RST && (cycCnt[k] < DEPTH)));
            checkOutput($sformatf("out_valid[%0d]", k), 32'(OUT_VALID[k]), 32'(cycCnt[k] > 0));
            checkOutput($sformatf("occupancy[%0d]", k), 32'(OCCUPANCY[k*CW +: CW]), 32'(cycCnt[k]));
            if (OUT_VALID[k] && OUT_READY[k] && !RST) begin
               if (expQ[k].size() == 0) begin
                  checkOutput($sformatf("unexpected_pop[%0d]", k), 32'(OUT_DATA[k*WIDTH +: WIDTH]), 32'hFFFF_FFFF);
               end else begin
                  logic [WIDTH-1:0] e;
                  e = expQ[k].pop_front();
                  checkOutput($sformatf("out_data[%0d]", k), 32'(OUT_DATA[k*WIDTH +: WIDTH]), 32'(e));
               end
            end
         end
      end
   end

   initial begin
      RST       = 1'b1;
      IN_VALID  = '0;
      OUT_READY = '0;
      IN_DATA   = '0;
      for (int k = 0; k < NCHAN; k++) begin
         modelCnt[k] = 0;
         cycCnt[k]   = 0;
      end
      monitorOn = 1'b1;
      doReset();

      // Single push on channel 0; channel 1 stays empty.
      applyStimulus(2'b01, 2'b00, {8'h00, 8'hA5});
      applyStimulus(2'b00, 2'b00, '0);
      checkOutput("single_push_data", 32'(OUT_DATA[7:0]), 32'hA5);
      checkOutput("single_push_ch1_idle", 32'(OUT_VALID[1]), 32'h0);
      applyStimulus(2'b00, 2'b01, '0);
      applyStimulus(2'b00, 2'b00, '0);

      // Fill channel 1 to full; the fifth word must be refused.
      for (int i = 1; i <= 5; i++) applyStimulus(2'b10, 2'b00, {8'(i), 8'h00});
      applyStimulus(2'b00, 2'b00, '0);
      checkOutput("full_in_ready1", 32'(IN_READY[1]), 32'h0);
      checkOutput("full_occupancy1", 32'(OCCUPANCY[CW +: CW]), 32'd4);
      repeat (5) applyStimulus(2'b00, 2'b10, '0);

      // Continuous push and pop across pointer wrap on channel 0.
      for (int i = 0; i < 10; i++) applyStimulus(2'b01, 2'b01, {8'h00, 8'(8'h10 + i)});
      applyStimulus(2'b00, 2'b01, '0);
      applyStimulus(2'b00, 2'b00, '0);

      // Push and pop together while full: only the pop happens.
      for (int i = 0; i < 4; i++) applyStimulus(2'b01, 2'b00, {8'h00, 8'(8'h20 + i)});
      applyStimulus(2'b01, 2'b01, {8'h00, 8'h24});
      applyStimulus(2'b01, 2'b00, {8'h00, 8'h25});
      applyStimulus(2'b00, 2'b00, '0);
      checkOutput("full_pushpop_occ", 32'(OCCUPANCY[0 +: CW]), 32'd4);
      repeat (4) applyStimulus(2'b00, 2'b01, '0);

      // Reset while both channels hold three entries.
      for (int i = 0; i < 3; i++) applyStimulus(2'b11, 2'b00, {8'(8'h50 + i), 8'(8'h40 + i)});
      doReset();
      applyStimulus(2'b11, 2'b00, {8'h77, 8'h66});
      applyStimulus(2'b00, 2'b11, '0);
      applyStimulus(2'b00, 2'b00, '0);

      // Random independent traffic with one reset in the middle.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) doReset();
         applyStimulus(NCHAN'($urandom), NCHAN'($urandom), (NCHAN*WIDTH)'($urandom));
      end

      // Drain and confirm nothing was left behind.
      repeat (DEPTH + 1) applyStimulus(2'b00, 2'b11, '0);
      applyStimulus(2'b00, 2'b00, '0);
      for (int k = 0; k < NCHAN; k++) begin
         checkOutput($sformatf("leftover[%0d]", k), 32'(expQ[k].size()), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/connectnet_pipe.md
CONNECTNET_PIPE -- requirements
Module: connectnet_pipe

Interface
REQ-001 Parameter NCHAN, default 2: number of independent channels.
REQ-002 Parameter WIDTH, default 1: data bits per channel.
REQ-003 Parameter DEPTH, default 2: entries per channel buffer; power of two, minimum 2.
REQ-004 Local AW = log2(DEPTH); CW = AW+1 is the count width.
REQ-005 CLK  input  1: single clock; all state is updated on its rising edge.
REQ-006 RST  input  1: reset, asynchronous and active-high.
REQ-007 IN_DATA  input  NCHAN*WIDTH: write data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 IN_VALID  input  NCHAN: per-channel write request.
REQ-009 IN_READY  output  NCHAN: per-channel space available.
REQ-010 OUT_DATA  output  NCHAN*WIDTH: head-entry data per channel, using the same lane packing as IN_DATA.
REQ-011 OUT_VALID  output  NCHAN: per-channel head entry valid.
REQ-012 OUT_READY  input  NCHAN: per-channel consumer accept.
REQ-013 OCCUPANCY  output  NCHAN*CW: per-channel entry count; channel k occupies bits [k*CW +: CW].

Function
REQ-014 Each channel SHALL be an independent FIFO; channels SHALL share no state other than CLK and RST.
REQ-015 A push on channel k SHALL occur on a rising edge only when IN_VALID[k] and IN_READY[k] are both 1.
REQ-016 A pop on channel k SHALL occur on a rising edge only when OUT_VALID[k] and OUT_READY[k] are both 1.
REQ-017 IN_READY[k] SHALL be 1 when count[k] < DEPTH and RST is 0.
- It is derived from registered count only.
- It is not combinationally dependent on OUT_READY.
- A full channel SHALL NOT accept a push in the same cycle it pops.
REQ-018 OUT_VALID[k] SHALL be 1 when count[k] > 0.
REQ-019 OUT_DATA for channel k SHALL be the oldest unpopped entry whenever OUT_VALID[k] is 1; its value is don't-care otherwise.
REQ-020 Latency:
- A datum pushed at edge N SHALL be presented on OUT with OUT_VALID=1 after edge N.
- There is no combinational fall-through from IN to OUT.
- Minimum latency is 1 cycle.
REQ-021 Throughput: a channel with 0 < count < DEPTH SHALL sustain one push and one pop per cycle.
REQ-022 Count update:
- Push only: count +1.
- Pop only: count -1.
- Push and pop together: count unchanged.
- Neither: count unchanged.
REQ-023 Simultaneous push and pop on a channel with count=1 SHALL pop the old entry and present the new entry on the next cycle.
REQ-024 Read and write pointers SHALL be AW bits each and SHALL wrap modulo DEPTH with no gap or skipped entry.
REQ-025 Ordering SHALL be strict FIFO per channel.
REQ-026 No data SHALL be lost or duplicated across pointer wrap.
REQ-027 Protocol violations SHALL leave state unchanged:
- IN_VALID=1 while IN_READY=0.
- OUT_READY=1 while OUT_VALID=0.
REQ-028 OCCUPANCY[k] SHALL equal count[k], registered, in the range 0..DEPTH.
REQ-029 Storage SHALL be per-channel register arrays with no reset requirement on the data contents.

Reset
REQ-030 While RST=1, regardless of CLK:
- All pointers and counts SHALL be 0.
- OUT_VALID SHALL be 0.
- OCCUPANCY SHALL be 0.
- IN_READY SHALL be 0.
REQ-031 On the first rising edge after RST falls, no push SHALL be taken; IN_READY rises combinationally when RST falls.
REQ-032 RST asserted mid-transfer SHALL discard all buffered entries on every channel immediately.
REQ-033 No partial or stale entry SHALL be presented after reset release.

Verification
REQ-034 Single push, NCHAN=2, WIDTH=8, DEPTH=4:
- Stimulus: push 0xA5 on channel 0 at edge 1, OUT_READY=0.
- Response: OUT_VALID[0]=1 and OUT_DATA[7:0]=0xA5 after edge 1; OCCUPANCY[0]=1; channel 1 is unaffected.
REQ-035 Fill to full:
- Stimulus: push 0x01..0x04 on channel 1 with OUT_READY=0, then a fifth push with 0x05.
- Response: IN_READY[1]=0 and OCCUPANCY[1]=4; 0x05 is not stored; draining yields 0x01, 0x02, 0x03, 0x04.
REQ-036 Wrap:
- Stimulus: on channel 0, 10 cycles of continuous push and pop with data 0x10..0x19 and OUT_READY=1.
- Response: output is 0x10..0x19 in order, with no bubbles after the first; OCCUPANCY stays at 1.
REQ-037 Simultaneous push and pop at full:
- Stimulus: channel full, IN_VALID=1, OUT_READY=1.
- Response: one pop only; count becomes 3; push accepted on the next cycle.
REQ-038 Reset mid-traffic:
- Stimulus: RST pulses while channels 0 and 1 hold 3 entries each.
- Response: OUT_VALID=0, OCCUPANCY=0 and IN_READY=0 immediately; after release, the first pushed word is the first word out.
REQ-039 Random stress: random independent valid/ready per channel against a scoreboard; no loss, reorder, or cross-channel leakage.
